// File: rtl/audio_voice_engine_pkg.sv
// audio_voice_engine_pkg: shared sweep FSM states and width helpers for the voice engine
package audio_voice_engine_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_LATCH} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int acc_w(input int sample_w, input int vol_w, input int num_voices);
    return sample_w + vol_w + clog2(num_voices);
  endfunction
  function automatic int duty_w(input int sample_w, input int num_voices);
    return sample_w + clog2(num_voices);
  endfunction
endpackage

// File: rtl/audio_voice_engine_if.sv
// audio_voice_engine_if: synchronous sample memory read port (data valid one cycle after rd)
interface audio_voice_engine_if #(
  parameter int ADDR_W   = 16,
  parameter int SAMPLE_W = 8
);
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_rd;
  logic [SAMPLE_W-1:0] mem_data;
  modport master (output mem_addr, output mem_rd, input mem_data);
  modport slave (input mem_addr, input mem_rd, output mem_data);
endinterface

// File: rtl/audio_voice_engine_modulator.sv
// audio_modulator: 1-bit output stage, PWM by default or first-order sigma-delta with AUDIO_SIGMA_DELTA_EN
module audio_modulator #(
  parameter int DUTY_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] i_duty,
  output logic              o_out
);
`ifdef AUDIO_SIGMA_DELTA_EN
  logic [DUTY_W:0] r_sd;
  always_ff @(posedge clk)
    r_sd <= rst ? '0 : {1'b0, r_sd[DUTY_W-1:0]} + {1'b0, i_duty};
  assign o_out = r_sd[DUTY_W];
`else
  logic [DUTY_W-1:0] r_cnt;
  logic              r_out;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      r_out <= r_cnt < i_duty;
    end
  end
  assign o_out = r_out;
`endif
endmodule

// File: rtl/audio_voice_engine.sv
// audio_voice_engine: N-voice PCM player with time-multiplexed fetch, mixer and 1-bit output.
// Define AUDIO_SIGMA_DELTA_EN to swap the PWM output stage for a sigma-delta modulator.
module audio_voice_engine
  import audio_voice_engine_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int SAMPLE_FREQ = 8000,
  parameter int NUM_VOICES  = 8,
  parameter int SAMPLE_W    = 8,
  parameter int ADDR_W      = 16,
  parameter int VOL_W       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_VOICES-1:0]        i_play,
  input  logic [NUM_VOICES-1:0]        i_stop,
  input  logic [NUM_VOICES-1:0]        i_voice_loop,
  input  logic [NUM_VOICES*ADDR_W-1:0] i_voice_start,
  input  logic [NUM_VOICES*ADDR_W-1:0] i_voice_len,
  input  logic [NUM_VOICES*VOL_W-1:0]  i_volume,
  audio_voice_engine_if.master         mem,
  output logic [NUM_VOICES-1:0]        o_active,
  output logic                         o_sample_tick,
  output logic                         o_out
);
  localparam int DIV    = CLK_FREQ / SAMPLE_FREQ;
  localparam int CNT_W  = clog2(DIV) > 0 ? clog2(DIV) : 1;
  localparam int VI_W   = NUM_VOICES > 1 ? clog2(NUM_VOICES) : 1;
  localparam int ACC_W  = acc_w(SAMPLE_W, VOL_W, NUM_VOICES);
  localparam int DUTY_W = duty_w(SAMPLE_W, NUM_VOICES);
  localparam int PROD_W = SAMPLE_W + VOL_W;
  if (DIV < NUM_VOICES + 3) begin : g_div_chk
    $error("audio_voice_engine: CLK_FREQ/SAMPLE_FREQ must be at least NUM_VOICES+3");
  end
  state_t                r_state, w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_tick;
  logic [VI_W-1:0]       r_v, r_prev_v;
  logic                  r_prev_rd;
  logic [ACC_W-1:0]      r_acc;
  logic [DUTY_W-1:0]     r_duty;
  logic [NUM_VOICES-1:0] r_active;
  logic [ADDR_W-1:0]     r_pos [NUM_VOICES];
  logic [ADDR_W-1:0]     w_start [NUM_VOICES];
  logic [ADDR_W-1:0]     w_len [NUM_VOICES];
  logic [VOL_W-1:0]      w_vol [NUM_VOICES];
  logic [NUM_VOICES-1:0] w_hit, w_end, w_trig;
  logic                  w_rd;
  logic [ADDR_W-1:0]     w_addr;
  logic [PROD_W-1:0]     w_prod;
  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    assign w_start[i] = i_voice_start[i*ADDR_W +: ADDR_W];
    assign w_len[i]   = i_voice_len[i*ADDR_W +: ADDR_W];
    assign w_vol[i]   = i_volume[i*VOL_W +: VOL_W];
    assign w_hit[i]   = r_prev_rd && r_prev_v == VI_W'(i);
    assign w_end[i]   = r_pos[i] == w_len[i] - 1'b1;
    assign w_trig[i]  = i_play[i] && !i_stop[i] && w_len[i] != '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= r_cnt == CNT_W'(DIV - 1) ? '0 : r_cnt + 1'b1;
      r_tick <= r_cnt == CNT_W'(DIV - 1);
    end
  end
  always_ff @(posedge clk)
    r_state <= rst ? S_IDLE : w_next;
  always_comb begin
    w_rd   = r_state == S_FETCH && r_active[r_v];
    w_addr = w_rd ? w_start[r_v] + r_pos[r_v] : '0;
    w_next = r_state == S_IDLE  ? (r_tick ? S_FETCH : S_IDLE) :
             r_state == S_FETCH ? (r_v == VI_W'(NUM_VOICES - 1) ? S_DRAIN : S_FETCH) :
             r_state == S_DRAIN ? S_LATCH : S_IDLE;
  end
  assign mem.mem_rd   = w_rd;
  assign mem.mem_addr = w_addr;
  assign w_prod = {{VOL_W{1'b0}}, mem.mem_data} * {{SAMPLE_W{1'b0}}, w_vol[r_prev_v]};
  // Accumulate lags the fetch by one cycle, so the read flag and voice index are carried forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v       <= '0;
      r_prev_v  <= '0;
      r_prev_rd <= 1'b0;
      r_acc     <= '0;
      r_duty    <= '0;
      r_active  <= '0;
      for (int i = 0; i < NUM_VOICES; i++) r_pos[i] <= '0;
    end else begin
      r_v       <= r_state == S_FETCH ? r_v + 1'b1 : '0;
      r_prev_v  <= r_v;
      r_prev_rd <= w_rd;
      r_acc     <= r_state == S_IDLE && r_tick ? '0 : r_prev_rd ? r_acc + ACC_W'(w_prod) : r_acc;
      if (r_state == S_LATCH) r_duty <= DUTY_W'(r_acc >> VOL_W);
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (w_trig[i]) begin
          r_active[i] <= 1'b1;
          r_pos[i]    <= '0;
        end else if (w_hit[i]) begin
          r_pos[i] <= w_end[i] ? '0 : r_pos[i] + 1'b1;
          if (w_end[i] && !i_voice_loop[i]) r_active[i] <= 1'b0;
        end
        if (i_stop[i]) r_active[i] <= 1'b0;
      end
    end
  end
  assign o_active      = r_active;
  assign o_sample_tick = r_tick;
  audio_modulator #(.DUTY_W(DUTY_W)) u_mod (
    .clk    (clk),
    .rst    (rst),
    .i_duty (r_duty),
    .o_out  (o_out)
  );
endmodule
